// File: rtl/updown_count_sequencer.sv
// Command-driven wrapping up/down counter: runs a requested number of steps,
// with hold/abort while running, and pulses done on completion.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// RUN   | stepping the counter once per cycle unless held or aborted
// DONE  | one-cycle completion pulse, then back to IDLE
module updown_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_up,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_load_val,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [1:0]       state;
    logic [LEN_W-1:0] remaining;
    logic             dir;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            wrap      <= 1'b0;
            remaining <= '0;
            dir       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    wrap <= 1'b0;
                    if (cmd_valid) begin
                        dir       <= cmd_up;
                        remaining <= cmd_len;
                        if (cmd_load)
                            count <= cmd_load_val;
                        // A zero-length command only performs the optional preload.
                        state <= (cmd_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        wrap  <= 1'b0;
                        state <= IDLE;
                    end else if (hold) begin
                        wrap <= 1'b0;
                    end else begin
                        if (dir) begin
                            count <= count + CNT_ONE;
                            wrap  <= &count;
                        end else begin
                            count <= count - CNT_ONE;
                            wrap  <= ~|count;
                        end
                        remaining <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE)
                            state <= DONE;
                    end
                end
                DONE: begin
                    wrap  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wrap  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Scoreboard bench: stimulus pushes the expected {count, wrap, done} for every
// busy/done cycle; a monitor pops and compares whenever the DUT is busy or done.
module tb_updown_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_up;
    logic [7:0] cmd_len;
    logic       cmd_load;
    logic [3:0] cmd_load_val;
    logic       hold;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    typedef struct packed {
        logic [3:0] cnt;
        logic       wr;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    updown_count_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_up(cmd_up),
        .cmd_len(cmd_len), .cmd_load(cmd_load), .cmd_load_val(cmd_load_val),
        .hold(hold), .abort(abort),
        .count(count), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int c, input int w, input int d);
        exp_t e;
        e.cnt = 4'(c);
        e.wr  = 1'(w);
        e.dn  = 1'(d);
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per cycle in which the DUT is busy or done.
    always @(negedge clk) begin
        if (busy || done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL scoreboard_unexpected: count=%0d wrap=%0d done=%0d with empty queue",
                         count, wrap, done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_count", int'(count), int'(e.cnt));
                check("sb_wrap",  int'(wrap),  int'(e.wr));
                check("sb_done",  int'(done),  int'(e.dn));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic issue(input logic up, input int len, input logic load, input int val);
        check("issue_ready", int'(cmd_ready), 1);
        cmd_up       = up;
        cmd_len      = 8'(len);
        cmd_load     = load;
        cmd_load_val = 4'(val);
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL wait_idle_timeout: cmd_ready=%0d, expected 1", cmd_ready);
        end
    endtask

    initial begin
        int cyc;
        int n;
        int last;

        reset = 1'b1; cmd_valid = 1'b0; cmd_up = 1'b1; cmd_len = '0;
        cmd_load = 1'b0; cmd_load_val = '0; hold = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_wrap",  int'(wrap), 0);
        check("rst_ready", int'(cmd_ready), 1);

        // 1: up 3 from 0
        push(0,0,0); push(1,0,0); push(2,0,0); push(3,0,1);
        issue(1'b1, 3, 1'b0, 0);
        wait_idle();

        // 2: up 3 from 14, wraps 15->0
        push(14,0,0); push(15,0,0); push(0,1,0); push(1,0,1);
        issue(1'b1, 3, 1'b1, 14);
        wait_idle();

        // 3: down 2 from 1, wraps 0->15 on the last step
        push(1,0,0); push(0,0,0); push(15,1,1);
        issue(1'b0, 2, 1'b1, 1);
        wait_idle();

        // 4: up 4 from 5 with two held cycles after the 2nd step
        push(5,0,0); push(6,0,0); push(7,0,0); push(7,0,0); push(7,0,0);
        push(8,0,0); push(9,0,1);
        issue(1'b1, 4, 1'b1, 5);
        repeat (2) @(negedge clk);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        hold = 1'b0;
        wait_idle();

        // 5: up 10 from 0, aborted after the 3rd step
        push(0,0,0); push(1,0,0); push(2,0,0); push(3,0,0);
        issue(1'b1, 10, 1'b1, 0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_count", int'(count), 3);
        check("abort_done",  int'(done), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_busy",  int'(busy), 0);

        // 5b: reset in the middle of a run
        push(3,0,0); push(4,0,0);
        issue(1'b1, 5, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_count", int'(count), 0);
        check("midrst_busy",  int'(busy), 0);
        check("midrst_done",  int'(done), 0);
        repeat (2) @(negedge clk);
        check("midrst_no_done", int'(done), 0);

        // 6: zero-length command with preload
        push(9,0,1);
        issue(1'b1, 0, 1'b1, 9);
        check("len0_busy",  int'(busy), 0);
        check("len0_count", int'(count), 9);
        @(negedge clk);
        check("len0_ready", int'(cmd_ready), 1);

        // 6b: cmd_valid held high, len=1 -> accepts every 3 cycles
        for (int i = 0; i < 4; i++) begin
            push(9 + i, 0, 0);
            push(10 + i, 0, 1);
        end
        cmd_up = 1'b1; cmd_len = 8'd1; cmd_load = 1'b0; cmd_valid = 1'b1;
        cyc = 0; n = 0; last = 0;
        while (n < 4 && cyc < 40) begin
            if (cmd_ready) begin
                if (n > 0) check("accept_spacing", cyc - last, 3);
                last = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("accept_total", n, 4);
        wait_idle();
        repeat (3) @(negedge clk);
        check("final_count", int'(count), 13);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $fatal(1, "timeout");
    end

endmodule
